// File: rtl/sq_multi_if.sv
// Bundle of all store-queue handshake, exec, forwarding and D-cache signals.
// The slave modport is the store queue; the master modport is its environment.
interface sq_multi_if #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int COMMIT_WIDTH   = 2,
  parameter int SQ_SIZE        = 16,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int ROB_W          = 6
);
  localparam int IDX_WIDTH = $clog2(SQ_SIZE);
  localparam int PTR_WIDTH = IDX_WIDTH + 1;
  localparam int CNT_W     = $clog2(COMMIT_WIDTH + 1);
  localparam int FREE_W    = $clog2(SQ_SIZE + 1);

  logic [DISPATCH_WIDTH-1:0]                enq_valid;
  logic [DISPATCH_WIDTH-1:0][1:0]           enq_size;
  logic [DISPATCH_WIDTH-1:0][ROB_W-1:0]     enq_rob_idx;
  logic                                     enq_ok;
  logic [DISPATCH_WIDTH-1:0][PTR_WIDTH-1:0] enq_sq_ptr;
  logic [PTR_WIDTH-1:0]                     tail_ptr;

  logic                 exec_valid;
  logic [PTR_WIDTH-1:0] exec_sq_ptr;
  logic [ADDR_W-1:0]    exec_addr;
  logic [DATA_W-1:0]    exec_data;

  logic [CNT_W-1:0]     commit_cnt;
  logic                 squash_valid;
  logic [PTR_WIDTH-1:0] squash_tail;

  logic                 ld_valid;
  logic [ADDR_W-1:0]    ld_addr;
  logic [1:0]           ld_size;
  logic [PTR_WIDTH-1:0] ld_tail;
  logic                 fwd_hit;
  logic [DATA_W-1:0]    fwd_data;
  logic                 fwd_stall;

  logic                 dc_req_valid;
  logic [ADDR_W-1:0]    dc_req_addr;
  logic [1:0]           dc_req_size;
  logic [DATA_W-1:0]    dc_req_data;
  logic                 dc_req_accept;

  logic [FREE_W-1:0]    free_num_slot;
  logic                 empty;

  modport slave (
    input  enq_valid, enq_size, enq_rob_idx,
    output enq_ok, enq_sq_ptr, tail_ptr,
    input  exec_valid, exec_sq_ptr, exec_addr, exec_data,
    input  commit_cnt, squash_valid, squash_tail,
    input  ld_valid, ld_addr, ld_size, ld_tail,
    output fwd_hit, fwd_data, fwd_stall,
    output dc_req_valid, dc_req_addr, dc_req_size, dc_req_data,
    input  dc_req_accept,
    output free_num_slot, empty
  );

  modport master (
    output enq_valid, enq_size, enq_rob_idx,
    input  enq_ok, enq_sq_ptr, tail_ptr,
    output exec_valid, exec_sq_ptr, exec_addr, exec_data,
    output commit_cnt, squash_valid, squash_tail,
    output ld_valid, ld_addr, ld_size, ld_tail,
    input  fwd_hit, fwd_data, fwd_stall,
    input  dc_req_valid, dc_req_addr, dc_req_size, dc_req_data,
    output dc_req_accept,
    input  free_num_slot, empty
  );
endinterface

// File: rtl/sq_multi.sv
// Store queue: multi-wide dispatch, in-order commit and D-cache drain,
// tail-rollback squash and a single combinational store-to-load forwarding port.
module sq_multi #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int COMMIT_WIDTH   = 2,
  parameter int SQ_SIZE        = 16,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic      clock,
  input  logic      reset,
  sq_multi_if.slave bus
);
  localparam int IDX_WIDTH = $clog2(SQ_SIZE);
  localparam int PTR_WIDTH = IDX_WIDTH + 1;
  localparam int PW1       = PTR_WIDTH + 1;
  localparam int CNT_W     = $clog2(COMMIT_WIDTH + 1);
  localparam int K_W       = $clog2(DISPATCH_WIDTH + 1);
  localparam int FREE_W    = $clog2(SQ_SIZE + 1);
  localparam int AW1       = ADDR_W + 1;

  logic [PTR_WIDTH-1:0] head_q, head_d, commit_q, commit_d, tail_q, tail_d;
  logic [SQ_SIZE-1:0]   valid_q, valid_d, committed_q, committed_d;
  logic [SQ_SIZE-1:0]   addr_valid_q, addr_valid_d, data_valid_q, data_valid_d;
  logic [ADDR_W-1:0]    addr_q [SQ_SIZE];
  logic [ADDR_W-1:0]    addr_d [SQ_SIZE];
  logic [DATA_W-1:0]    data_q [SQ_SIZE];
  logic [DATA_W-1:0]    data_d [SQ_SIZE];
  logic [1:0]           size_q [SQ_SIZE];
  logic [1:0]           size_d [SQ_SIZE];

  logic [PTR_WIDTH-1:0] occupancy, free_cnt, sq_cnt;
  logic [K_W-1:0]       enq_k;
  logic [DISPATCH_WIDTH-1:0][PTR_WIDTH-1:0] enq_ptr;
  logic                 enq_ok;
  logic [IDX_WIDTH-1:0] head_idx, exec_idx, sq_off;
  logic [SQ_SIZE-1:0]   in_squash;
  logic                 dc_valid, pop;
  logic                 unused_bits;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    size_bytes = 3'd1;
      2'd1:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  assign occupancy = tail_q - head_q;
  assign free_cnt  = PTR_WIDTH'(SQ_SIZE) - occupancy;
  assign sq_cnt    = tail_q - bus.squash_tail;
  assign head_idx  = head_q[IDX_WIDTH-1:0];
  assign exec_idx  = bus.exec_sq_ptr[IDX_WIDTH-1:0];
  assign unused_bits = ^{bus.enq_rob_idx, bus.exec_sq_ptr[PTR_WIDTH-1]};

  // Slot s gets tail plus the number of requesting slots below it.
  always_comb begin
    enq_k   = '0;
    enq_ptr = '0;
    for (int s = 0; s < DISPATCH_WIDTH; s++) begin
      enq_ptr[s] = tail_q + PTR_WIDTH'(enq_k);
      if (bus.enq_valid[s]) enq_k = enq_k + 1'b1;
    end
  end

  assign enq_ok = (PTR_WIDTH'(enq_k) <= free_cnt) && !bus.squash_valid;

  always_comb begin
    in_squash = '0;
    sq_off    = '0;
    for (int i = 0; i < SQ_SIZE; i++) begin
      sq_off       = IDX_WIDTH'(i) - bus.squash_tail[IDX_WIDTH-1:0];
      in_squash[i] = bus.squash_valid && ({1'b0, sq_off} < sq_cnt);
    end
  end

  assign dc_valid = valid_q[head_idx] & committed_q[head_idx] &
                    addr_valid_q[head_idx] & data_valid_q[head_idx];
  assign pop      = dc_valid & bus.dc_req_accept;

  always_comb begin
    valid_d      = valid_q;
    committed_d  = committed_q;
    addr_valid_d = addr_valid_q;
    data_valid_d = data_valid_q;
    addr_d       = addr_q;
    data_d       = data_q;
    size_d       = size_q;

    if (pop) begin
      valid_d[head_idx]      = 1'b0;
      committed_d[head_idx]  = 1'b0;
      addr_valid_d[head_idx] = 1'b0;
      data_valid_d[head_idx] = 1'b0;
    end

    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      if (CNT_W'(j) < bus.commit_cnt)
        committed_d[commit_q[IDX_WIDTH-1:0] + IDX_WIDTH'(j)] = 1'b1;
    end

    for (int i = 0; i < SQ_SIZE; i++) begin
      if (in_squash[i]) begin
        valid_d[i]      = 1'b0;
        addr_valid_d[i] = 1'b0;
        data_valid_d[i] = 1'b0;
      end
    end

    if (bus.exec_valid && valid_q[exec_idx] && !in_squash[exec_idx]) begin
      addr_d[exec_idx]       = bus.exec_addr;
      data_d[exec_idx]       = bus.exec_data;
      addr_valid_d[exec_idx] = 1'b1;
      data_valid_d[exec_idx] = 1'b1;
    end

    if (enq_ok) begin
      for (int s = 0; s < DISPATCH_WIDTH; s++) begin
        if (bus.enq_valid[s]) begin
          valid_d[enq_ptr[s][IDX_WIDTH-1:0]]      = 1'b1;
          committed_d[enq_ptr[s][IDX_WIDTH-1:0]]  = 1'b0;
          addr_valid_d[enq_ptr[s][IDX_WIDTH-1:0]] = 1'b0;
          data_valid_d[enq_ptr[s][IDX_WIDTH-1:0]] = 1'b0;
          size_d[enq_ptr[s][IDX_WIDTH-1:0]]       = bus.enq_size[s];
        end
      end
    end

    head_d   = pop ? head_q + 1'b1 : head_q;
    commit_d = commit_q + PTR_WIDTH'(bus.commit_cnt);
    if (bus.squash_valid) tail_d = bus.squash_tail;
    else if (enq_ok)      tail_d = tail_q + PTR_WIDTH'(enq_k);
    else                  tail_d = tail_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q       <= '0;
      commit_q     <= '0;
      tail_q       <= '0;
      valid_q      <= '0;
      committed_q  <= '0;
      addr_valid_q <= '0;
      data_valid_q <= '0;
      for (int i = 0; i < SQ_SIZE; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        size_q[i] <= '0;
      end
    end else begin
      head_q       <= head_d;
      commit_q     <= commit_d;
      tail_q       <= tail_d;
      valid_q      <= valid_d;
      committed_q  <= committed_d;
      addr_valid_q <= addr_valid_d;
      data_valid_q <= data_valid_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      size_q       <= size_d;
    end
  end

  // Forwarding walks youngest-first from ld_tail-1; the first unknown or overlapping store decides.
  logic [PTR_WIDTH-1:0] search_cnt;
  logic [IDX_WIDTH-1:0] fwd_idx;
  logic [AW1-1:0]       ld_lo, ld_hi, st_lo, st_hi;
  logic [2:0]           ld_bytes;
  logic [1:0]           fwd_shift;
  logic [DATA_W-1:0]    fwd_raw, fwd_data;
  logic                 fwd_found, fwd_hit, fwd_stall;

  always_comb begin
    search_cnt = bus.ld_tail - head_q;
    ld_bytes   = size_bytes(bus.ld_size);
    ld_lo      = {1'b0, bus.ld_addr};
    ld_hi      = ld_lo + AW1'(ld_bytes);
    fwd_idx    = '0;
    st_lo      = '0;
    st_hi      = '0;
    fwd_shift  = '0;
    fwd_raw    = '0;
    fwd_data   = '0;
    fwd_found  = 1'b0;
    fwd_hit    = 1'b0;
    fwd_stall  = 1'b0;
    for (int j = 0; j < SQ_SIZE; j++) begin
      fwd_idx = bus.ld_tail[IDX_WIDTH-1:0] - IDX_WIDTH'(j + 1);
      st_lo   = {1'b0, addr_q[fwd_idx]};
      st_hi   = st_lo + AW1'(size_bytes(size_q[fwd_idx]));
      if (bus.ld_valid && !fwd_found && (PTR_WIDTH'(j) < search_cnt) && valid_q[fwd_idx]) begin
        if (!addr_valid_q[fwd_idx]) begin
          fwd_found = 1'b1;
          fwd_stall = 1'b1;
        end else if ((ld_lo < st_hi) && (st_lo < ld_hi)) begin
          fwd_found = 1'b1;
          if ((st_lo <= ld_lo) && (ld_hi <= st_hi)) begin
            fwd_hit   = 1'b1;
            fwd_shift = bus.ld_addr[1:0] - addr_q[fwd_idx][1:0];
            fwd_raw   = data_q[fwd_idx] >> {fwd_shift, 3'b000};
            case (ld_bytes)
              3'd1:    fwd_data = fwd_raw & DATA_W'(32'h0000_00FF);
              3'd2:    fwd_data = fwd_raw & DATA_W'(32'h0000_FFFF);
              default: fwd_data = fwd_raw;
            endcase
          end else begin
            fwd_stall = 1'b1;
          end
        end
      end
    end
  end

  assign bus.enq_ok        = enq_ok;
  assign bus.enq_sq_ptr    = enq_ptr;
  assign bus.tail_ptr      = tail_q;
  assign bus.fwd_hit       = fwd_hit;
  assign bus.fwd_data      = fwd_data;
  assign bus.fwd_stall     = fwd_stall;
  assign bus.dc_req_valid  = dc_valid;
  assign bus.dc_req_addr   = addr_q[head_idx];
  assign bus.dc_req_size   = size_q[head_idx];
  assign bus.dc_req_data   = data_q[head_idx];
  assign bus.free_num_slot = FREE_W'(free_cnt);
  assign bus.empty         = (occupancy == '0);

  // Squash plus commit together may only consume stores that are still uncommitted.
  logic [PW1-1:0] uncommitted_cnt, retire_need;
  assign uncommitted_cnt = {1'b0, tail_q - commit_q};
  assign retire_need     = (bus.squash_valid ? {1'b0, sq_cnt} : PW1'(0)) + PW1'(bus.commit_cnt);

  a_retire_bound: assert property (@(posedge clock) disable iff (!reset)
                                   retire_need <= uncommitted_cnt);
endmodule

// File: tb/tb_sq_multi.sv
// Directed self-checking bench for sq_multi: enqueue, exec, commit, drain,
// forwarding, squash rollback, fill/full boundaries, pointer wrap and async reset.
module tb_sq_multi;
  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   drained;
  logic [4:0] ptr_m;

  sq_multi_if #(.DISPATCH_WIDTH(2), .COMMIT_WIDTH(2), .SQ_SIZE(16),
                .ADDR_W(32), .DATA_W(32), .ROB_W(6)) bus ();

  sq_multi #(.DISPATCH_WIDTH(2), .COMMIT_WIDTH(2), .SQ_SIZE(16),
             .ADDR_W(32), .DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clearInputs();
    bus.enq_valid     = '0;
    bus.enq_size      = {2'd2, 2'd2};
    bus.enq_rob_idx   = '0;
    bus.exec_valid    = 1'b0;
    bus.exec_sq_ptr   = '0;
    bus.exec_addr     = '0;
    bus.exec_data     = '0;
    bus.commit_cnt    = '0;
    bus.squash_valid  = 1'b0;
    bus.squash_tail   = '0;
    bus.ld_valid      = 1'b0;
    bus.ld_addr       = '0;
    bus.ld_size       = '0;
    bus.ld_tail       = '0;
    bus.dc_req_accept = 1'b0;
  endtask

  task automatic driveExec(input logic [4:0] ptr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] cnt);
    bus.exec_valid  = 1'b1;
    bus.exec_sq_ptr = ptr;
    bus.exec_addr   = addr;
    bus.exec_data   = data;
    bus.commit_cnt  = cnt;
  endtask

  task automatic stopExec();
    bus.exec_valid = 1'b0;
    bus.commit_cnt = '0;
  endtask

  task automatic applyStimulus(input logic [4:0] tail, input logic [31:0] addr, input logic [1:0] size);
    bus.ld_valid = 1'b1;
    bus.ld_tail  = tail;
    bus.ld_addr  = addr;
    bus.ld_size  = size;
    settle();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    drained = 0;
    reset   = 1'b0;
    clearInputs();
    repeat (2) tick();
    checkOutput("rst_free", 32'(bus.free_num_slot), 32'd16);
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("rst_dc_valid", 32'(bus.dc_req_valid), 32'd0);
    checkOutput("rst_tail", 32'(bus.tail_ptr), 32'd0);
    applyStimulus(5'd0, 32'h100, 2'd2);
    checkOutput("rst_fwd_hit", 32'(bus.fwd_hit), 32'd0);
    checkOutput("rst_fwd_stall", 32'(bus.fwd_stall), 32'd0);
    bus.ld_valid = 1'b0;
    reset = 1'b1;
    tick();

    $display("[TB] dual enqueue after reset");
    bus.enq_valid = 2'b11;
    settle();
    checkOutput("enq2_ok", 32'(bus.enq_ok), 32'd1);
    checkOutput("enq2_ptr0", 32'(bus.enq_sq_ptr[0]), 32'd0);
    checkOutput("enq2_ptr1", 32'(bus.enq_sq_ptr[1]), 32'd1);
    tick();
    bus.enq_valid = 2'b00;
    checkOutput("enq2_free", 32'(bus.free_num_slot), 32'd14);
    checkOutput("enq2_empty", 32'(bus.empty), 32'd0);
    checkOutput("enq2_tail", 32'(bus.tail_ptr), 32'd2);

    $display("[TB] exec, commit, forwarding and held drain");
    driveExec(5'd0, 32'h100, 32'hAABBCCDD, 2'd1);
    tick();
    stopExec();
    checkOutput("dc_valid", 32'(bus.dc_req_valid), 32'd1);
    checkOutput("dc_addr", bus.dc_req_addr, 32'h100);
    checkOutput("dc_data", bus.dc_req_data, 32'hAABBCCDD);
    checkOutput("dc_size", 32'(bus.dc_req_size), 32'd2);
    applyStimulus(5'd1, 32'h102, 2'd1);
    checkOutput("fwd_half_hit", 32'(bus.fwd_hit), 32'd1);
    checkOutput("fwd_half_data", bus.fwd_data, 32'h0000AABB);
    checkOutput("fwd_half_stall", 32'(bus.fwd_stall), 32'd0);
    applyStimulus(5'd1, 32'h103, 2'd0);
    checkOutput("fwd_byte_data", bus.fwd_data, 32'h000000AA);
    applyStimulus(5'd1, 32'h102, 2'd2);
    checkOutput("fwd_partial_stall", 32'(bus.fwd_stall), 32'd1);
    checkOutput("fwd_partial_hit", 32'(bus.fwd_hit), 32'd0);
    applyStimulus(5'd2, 32'h200, 2'd0);
    checkOutput("fwd_unknown_stall", 32'(bus.fwd_stall), 32'd1);
    applyStimulus(5'd2, 32'h100, 2'd2);
    checkOutput("fwd_youngest_stall", 32'(bus.fwd_stall), 32'd1);
    checkOutput("fwd_youngest_hit", 32'(bus.fwd_hit), 32'd0);
    applyStimulus(5'd1, 32'h300, 2'd2);
    checkOutput("fwd_miss_hit", 32'(bus.fwd_hit), 32'd0);
    checkOutput("fwd_miss_stall", 32'(bus.fwd_stall), 32'd0);
    applyStimulus(5'd1, 32'h100, 2'd2);
    bus.ld_valid = 1'b0;
    settle();
    checkOutput("fwd_ld_invalid", 32'(bus.fwd_hit), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("hold_valid", 32'(bus.dc_req_valid), 32'd1);
      checkOutput("hold_addr", bus.dc_req_addr, 32'h100);
      checkOutput("hold_data", bus.dc_req_data, 32'hAABBCCDD);
    end
    bus.dc_req_accept = 1'b1;
    tick();
    bus.dc_req_accept = 1'b0;
    checkOutput("pop_free", 32'(bus.free_num_slot), 32'd15);
    checkOutput("pop_dc_valid", 32'(bus.dc_req_valid), 32'd0);
    checkOutput("pop_empty", 32'(bus.empty), 32'd0);

    $display("[TB] squash rollback");
    bus.enq_valid = 2'b11;
    settle();
    checkOutput("sq_enq_ptr0", 32'(bus.enq_sq_ptr[0]), 32'd2);
    checkOutput("sq_enq_ptr1", 32'(bus.enq_sq_ptr[1]), 32'd3);
    tick();
    bus.enq_valid = 2'b01;
    driveExec(5'd2, 32'h400, 32'h11223344, 2'd0);
    settle();
    checkOutput("sq_enq_ptr4", 32'(bus.enq_sq_ptr[0]), 32'd4);
    tick();
    bus.enq_valid = 2'b00;
    stopExec();
    checkOutput("pre_sq_tail", 32'(bus.tail_ptr), 32'd5);
    checkOutput("pre_sq_free", 32'(bus.free_num_slot), 32'd12);
    bus.squash_valid = 1'b1;
    bus.squash_tail  = 5'd3;
    bus.enq_valid    = 2'b01;
    settle();
    checkOutput("sq_enq_blocked", 32'(bus.enq_ok), 32'd0);
    tick();
    bus.squash_valid = 1'b0;
    bus.enq_valid    = 2'b00;
    checkOutput("sq_tail", 32'(bus.tail_ptr), 32'd3);
    checkOutput("sq_free", 32'(bus.free_num_slot), 32'd14);
    applyStimulus(5'd5, 32'h400, 2'd2);
    checkOutput("sq_skip_hit", 32'(bus.fwd_hit), 32'd1);
    checkOutput("sq_skip_data", bus.fwd_data, 32'h11223344);
    bus.ld_valid = 1'b0;

    driveExec(5'd1, 32'h500, 32'h55, 2'd2);
    bus.dc_req_accept = 1'b1;
    tick();
    stopExec();
    checkOutput("drainA_valid", 32'(bus.dc_req_valid), 32'd1);
    checkOutput("drainA_addr", bus.dc_req_addr, 32'h500);
    tick();
    checkOutput("drainB_valid", 32'(bus.dc_req_valid), 32'd1);
    checkOutput("drainB_addr", bus.dc_req_addr, 32'h400);
    tick();
    bus.dc_req_accept = 1'b0;
    checkOutput("drainC_empty", 32'(bus.empty), 32'd1);
    checkOutput("drainC_free", 32'(bus.free_num_slot), 32'd16);

    $display("[TB] fill to full");
    bus.enq_valid = 2'b10;
    settle();
    checkOutput("fill_slot1_ok", 32'(bus.enq_ok), 32'd1);
    checkOutput("fill_slot1_ptr", 32'(bus.enq_sq_ptr[1]), 32'd3);
    tick();
    bus.enq_valid = 2'b11;
    repeat (7) tick();
    bus.enq_valid = 2'b00;
    checkOutput("fill15_free", 32'(bus.free_num_slot), 32'd1);
    checkOutput("fill15_tail", 32'(bus.tail_ptr), 32'd18);
    bus.enq_valid = 2'b11;
    settle();
    checkOutput("fill_over_ok", 32'(bus.enq_ok), 32'd0);
    tick();
    checkOutput("fill_over_tail", 32'(bus.tail_ptr), 32'd18);
    bus.enq_valid = 2'b00;
    settle();
    checkOutput("fill_k0_ok", 32'(bus.enq_ok), 32'd1);
    bus.enq_valid = 2'b01;
    settle();
    checkOutput("fill_last_ok", 32'(bus.enq_ok), 32'd1);
    checkOutput("fill_last_ptr", 32'(bus.enq_sq_ptr[0]), 32'd18);
    tick();
    bus.enq_valid = 2'b00;
    checkOutput("full_free", 32'(bus.free_num_slot), 32'd0);
    checkOutput("full_tail", 32'(bus.tail_ptr), 32'd19);
    checkOutput("full_empty", 32'(bus.empty), 32'd0);
    bus.enq_valid = 2'b10;
    settle();
    checkOutput("full_enq_ok", 32'(bus.enq_ok), 32'd0);
    bus.enq_valid = 2'b00;

    $display("[TB] drain sixteen entries");
    bus.dc_req_accept = 1'b1;
    for (int i = 0; i < 16; i++) begin
      driveExec(5'(3 + i), 32'h1000 + 32'(4 * i), 32'(i), 2'd1);
      settle();
      if (bus.dc_req_valid) begin
        checkOutput("drain_addr", bus.dc_req_addr, 32'h1000 + 32'(4 * drained));
        drained++;
      end
      tick();
    end
    stopExec();
    for (int c = 0; c < 20; c++) begin
      settle();
      if (bus.empty) break;
      if (bus.dc_req_valid) begin
        checkOutput("drain_addr", bus.dc_req_addr, 32'h1000 + 32'(4 * drained));
        drained++;
      end
      tick();
    end
    bus.dc_req_accept = 1'b0;
    checkOutput("drain_count", 32'(drained), 32'd16);
    checkOutput("drain_empty", 32'(bus.empty), 32'd1);
    checkOutput("drain_free", 32'(bus.free_num_slot), 32'd16);

    $display("[TB] forty enqueue/drain pairs across the wrap");
    ptr_m = 5'd19;
    for (int i = 0; i < 40; i++) begin
      bus.enq_valid = 2'b01;
      settle();
      checkOutput("wrap_ok", 32'(bus.enq_ok), 32'd1);
      checkOutput("wrap_ptr", 32'(bus.enq_sq_ptr[0]), 32'(ptr_m));
      tick();
      bus.enq_valid = 2'b00;
      driveExec(ptr_m, 32'h2000 + 32'(4 * i), 32'(i), 2'd1);
      bus.dc_req_accept = 1'b1;
      tick();
      stopExec();
      checkOutput("wrap_dc_valid", 32'(bus.dc_req_valid), 32'd1);
      checkOutput("wrap_free_le16", 32'(bus.free_num_slot <= 5'd16), 32'd1);
      tick();
      checkOutput("wrap_empty", 32'(bus.empty), 32'd1);
      ptr_m = ptr_m + 5'd1;
    end
    bus.dc_req_accept = 1'b0;
    checkOutput("wrap_tail", 32'(bus.tail_ptr), 32'd27);
    checkOutput("wrap_free", 32'(bus.free_num_slot), 32'd16);

    $display("[TB] reset during a pending drain");
    bus.enq_valid = 2'b01;
    tick();
    bus.enq_valid = 2'b00;
    driveExec(5'd27, 32'h3000, 32'h77, 2'd1);
    tick();
    stopExec();
    checkOutput("mid_dc_valid", 32'(bus.dc_req_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_dc_valid", 32'(bus.dc_req_valid), 32'd0);
    checkOutput("mid_rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("mid_rst_free", 32'(bus.free_num_slot), 32'd16);
    checkOutput("mid_rst_tail", 32'(bus.tail_ptr), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("post_rst_empty", 32'(bus.empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sq_multi.md
Name: sq_multi

Overview:
Parametrised next-generation store queue. It accepts up to DISPATCH_WIDTH stores per cycle at dispatch and takes address/data from the store FU, addressed by SQ index. It marks stores committed in order from ROB retire counts, drains committed stores to the D-cache over a valid/accept handshake, and answers one combinational store-to-load forwarding query. Branch recovery is a tail rollback to a saved SQ pointer, not a full-array snapshot.

Parameters:
DISPATCH_WIDTH, 2, max store enqueues per cycle
COMMIT_WIDTH, 2, max stores marked committed per cycle
SQ_SIZE, 16, entries; must be a power of 2, at least 4
IDX_WIDTH, $clog2(SQ_SIZE), entry index width
PTR_WIDTH, IDX_WIDTH+1, pointer width; MSB is the wrap bit

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
enq_valid  in  DISPATCH_WIDTH  per-slot enqueue request, any bit pattern
enq_size  in  DISPATCH_WIDTH x MEM_SIZE  access size per slot
enq_rob_idx  in  DISPATCH_WIDTH x ROB_IDX  ROB tag per slot
enq_ok  out  1  requested enqueues accepted this cycle (combinational)
enq_sq_ptr  out  DISPATCH_WIDTH x PTR_WIDTH  pointer assigned to each requesting slot
tail_ptr  out  PTR_WIDTH  current tail; loads and branches save it at dispatch
exec_valid  in  1  store FU result valid
exec_sq_ptr  in  PTR_WIDTH  target entry
exec_addr  in  ADDR  store address
exec_data  in  DATA  store data, 32 bits, right-aligned
commit_cnt  in  $clog2(COMMIT_WIDTH+1)  number of stores retired by the ROB this cycle
squash_valid  in  1  branch mispredict rollback
squash_tail  in  PTR_WIDTH  tail pointer saved at the branch
ld_valid  in  1  forwarding query
ld_addr  in  ADDR  load address
ld_size  in  MEM_SIZE  load size
ld_tail  in  PTR_WIDTH  SQ tail saved at load dispatch; only older stores are searched
fwd_hit  out  1  forwarded data valid
fwd_data  out  DATA  forwarded bytes, right-aligned, zero-extended
fwd_stall  out  1  load must wait
dc_req_valid  out  1  head store ready for the D-cache
dc_req_addr  out  ADDR  store address
dc_req_size  out  MEM_SIZE  store size
dc_req_data  out  DATA  store data
dc_req_accept  in  1  D-cache accepts the store
free_num_slot  out  $clog2(SQ_SIZE+1)  SQ_SIZE minus occupied entries
empty  out  1  no occupied entries

Behaviour:
- Reset (reset=0, asynchronous): head, commit and tail pointers all 0; every entry valid/addr_valid/data_valid/committed cleared. Outputs: free_num_slot=SQ_SIZE, empty=1, dc_req_valid=0, fwd_hit=0, fwd_stall=0. If reset asserts mid-drain, the in-flight request is dropped with no pop.
- Occupancy = tail-head, computed modulo 2^PTR_WIDTH. Full when the index bits are equal and the wrap bits differ.
- Enqueue, all-or-nothing: let K = popcount(enq_valid). enq_ok = (K <= free_num_slot) and squash_valid=0.
  - On enq_ok, set bits take consecutive pointers starting at tail, in slot order.
  - Each new entry: valid=1, committed=0, addr_valid=0, data_valid=0. tail advances by K.
  - enq_sq_ptr is valid for set bits whenever enq_ok=1.
- Exec: entry[exec_sq_ptr] gets addr and data, addr_valid=1 and data_valid=1 on the next edge.
  - Ignored if the entry is not valid or is squashed in the same cycle.
  - An exec write and an enqueue to the same entry in one cycle is illegal.
- Commit: the next commit_cnt entries from the commit pointer get committed=1, and the commit pointer advances.
  - commit_cnt exceeding the uncommitted valid count is an assertion failure.
- Drain:
  - dc_req_valid = head valid & committed & addr_valid & data_valid. Fields driven from head.
  - On dc_req_valid & dc_req_accept: the head entry is cleared and head advances by 1.
  - At most one drain per cycle.
  - dc_req_valid and its fields stay stable until accepted.
- Squash:
  - Entries from squash_tail up to tail-1 are invalidated and tail <= squash_tail.
  - Same-cycle enqueues are dropped.
  - Same-cycle drain and commit still apply; squash never reaches committed entries (assertion).
  - squash_tail == tail is a no-op.
- Forwarding (combinational, only while ld_valid=1): search valid entries from ld_tail-1 back to head, youngest first; stop at the first entry that is either address-unknown or overlapping.
  - Address-unknown (addr_valid=0): fwd_stall=1.
  - Overlap, and the store byte range fully covers the load: fwd_hit=1, fwd_data = store data shifted right by 8*(ld_addr-store_addr) and masked to ld_size.
  - Partial overlap: fwd_stall=1.
  - No match: both 0.
  - Size encoding: BYTE=1, HALF=2, WORD=4 bytes. DOUBLE is treated as WORD.
- Wrap-around: all pointer arithmetic is modulo 2^PTR_WIDTH and indexing uses the low IDX_WIDTH bits.
- Simultaneous events:
  - Enqueue and drain in one cycle: free_num_slot changes by 1-K.
  - Commit and drain of the same head entry in one cycle cannot occur, since drain requires committed already set.

Test Plan:
- Reset then enq_valid=2'b11 with SQ_SIZE=16 -> enq_ok=1, enq_sq_ptr={0,1}, free_num_slot=14 next cycle, empty=0.
- Fill to 15 entries, then enq_valid=2'b11 -> enq_ok=0, tail unchanged. Next enq_valid=2'b01 -> accepted, free_num_slot=0.
- Exec ptr0 addr=0x100 data=0xAABBCCDD, commit_cnt=1, dc_req_accept held 0 for 3 cycles -> dc_req_valid=1 with stable fields. accept=1 -> head=1 next cycle.
- Store WORD 0x100=0xAABBCCDD older than load HALF 0x102 -> fwd_hit=1, fwd_data=0x0000AABB. An older store at ptr with addr_valid=0 -> fwd_stall=1.
- Tail=5, squash_tail=3 with simultaneous enq_valid=2'b01 -> tail=3, entries 3 and 4 invalid, enq_ok=0, free_num_slot increases by 2.
- Run 40 enqueue/drain pairs -> pointers wrap past 15, wrap bit toggles, free_num_slot never exceeds 16, empty=1 at end.
